// File: rtl/counter_fsm.sv
// ============================================================================
// Module   : counter_fsm
// Purpose  : Binary-encoded Moore up-counter FSM (S0..S<MAX_COUNT>) with
//            terminal-count decode and a registered wrap pulse.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module counter_fsm #(
    parameter int WIDTH     = 4,
    parameter int MAX_COUNT = 15
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             wrap
);

    typedef logic [WIDTH-1:0] state_t;

    // State code equals the count value; only the two ends need names.
    localparam state_t C_S0   = '0;
    localparam state_t C_SMAX = MAX_COUNT[WIDTH-1:0];

    state_t r_state;
    state_t w_next;
    logic   r_wrap;
    logic   w_wrap_next;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= C_S0;
            r_wrap  <= 1'b0;
        end else begin
            r_state <= w_next;
            r_wrap  <= w_wrap_next;
        end
    end

    // An X on en falls to the hold path, so the state never goes unknown.
    always_comb begin
        w_next      = r_state;
        w_wrap_next = 1'b0;
        if (r_state > C_SMAX) begin
            w_next = C_S0;
        end else if (en) begin
            if (r_state == C_SMAX) begin
                w_next      = C_S0;
                w_wrap_next = 1'b1;
            end else begin
                w_next = r_state + state_t'(1);
            end
        end
    end

    assign count = r_state;
    assign tc    = (r_state == C_SMAX);
    assign wrap  = r_wrap;

endmodule

`default_nettype wire

// File: tb/tb_counter_fsm.sv
// ============================================================================
// Module   : tb_counter_fsm
// Purpose  : Directed checks of counter_fsm (default 4-bit/15 and 3-bit/5).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_counter_fsm;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic [3:0] count;
    logic       tc;
    logic       wrap;

    logic       rst3;
    logic       en3;
    logic [2:0] count3;
    logic       tc3;
    logic       wrap3;

    int vectors = 0;
    int errors  = 0;

    always #5 clk = ~clk;

    counter_fsm #(.WIDTH(4), .MAX_COUNT(15)) dut (
        .clk   (clk),
        .rst   (rst),
        .en    (en),
        .count (count),
        .tc    (tc),
        .wrap  (wrap)
    );

    counter_fsm #(.WIDTH(3), .MAX_COUNT(5)) dut3 (
        .clk   (clk),
        .rst   (rst3),
        .en    (en3),
        .count (count3),
        .tc    (tc3),
        .wrap  (wrap3)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input int c, input bit t, input bit w);
        chk({tag, ".count"}, 32'(count), 32'(c));
        chk({tag, ".tc"},    32'(tc),    32'(t));
        chk({tag, ".wrap"},  32'(wrap),  32'(w));
    endtask

    initial begin
        int exp_c;

        // Reset with en low/undriven
        rst  = 1'b1;
        en   = 1'bx;
        rst3 = 1'b1;
        en3  = 1'b0;
        step();
        chk_all("reset", 0, 1'b0, 1'b0);
        rst = 1'b0;
        for (int i = 0; i < 30; i++) begin
            en = (i < 15) ? 1'bx : 1'b0;
            step();
            chk("idle.count", 32'(count), 32'd0);
        end

        // 30 enabled edges: 1..15, 0..14 with one tc period and one wrap
        en = 1'b1;
        for (int i = 1; i <= 30; i++) begin
            step();
            exp_c = i % 16;
            chk_all("run", exp_c, exp_c == 15, i == 16);
        end
        en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            chk_all("hold14", 14, 1'b0, 1'b0);
        end

        // Hold / resume at 5
        rst = 1'b1;
        step();
        chk_all("rst2", 0, 1'b0, 1'b0);
        rst = 1'b0;
        en  = 1'b1;
        for (int i = 0; i < 5; i++) step();
        chk("to5.count", 32'(count), 32'd5);
        en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("hold5.count", 32'(count), 32'd5);
        end
        en = 1'b1;
        step();
        chk("resume.count", 32'(count), 32'd6);

        // Reset mid-count overrides en
        for (int i = 0; i < 3; i++) step();
        chk("to9.count", 32'(count), 32'd9);
        rst = 1'b1;
        step();
        chk_all("midrst", 0, 1'b0, 1'b0);
        rst = 1'b0;
        step();
        chk_all("postrst", 1, 1'b0, 1'b0);

        // Reset on the wrapping edge suppresses wrap
        for (int i = 0; i < 14; i++) step();
        chk_all("to15", 15, 1'b1, 1'b0);
        rst = 1'b1;
        step();
        chk_all("wraprst", 0, 1'b0, 1'b0);
        rst = 1'b0;
        en  = 1'b0;

        // WIDTH=3, MAX_COUNT=5
        rst3 = 1'b0;
        chk("p3.reset.count", 32'(count3), 32'd0);
        en3 = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            step();
            exp_c = i % 6;
            chk("p3.count", 32'(count3), 32'(exp_c));
            chk("p3.tc",    32'(tc3),    32'(exp_c == 5));
            chk("p3.wrap",  32'(wrap3),  32'(i == 6));
        end

        // Illegal code 7 returns to 0 even with en low
        en3 = 1'b0;
        @(negedge clk);
        force dut3.r_state = 3'd7;
        #1;
        chk("p3.forced.count", 32'(count3), 32'd7);
        chk("p3.forced.tc",    32'(tc3),    32'd0);
        release dut3.r_state;
        step();
        chk("p3.illegal.count", 32'(count3), 32'd0);
        chk("p3.illegal.wrap",  32'(wrap3),  32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

`default_nettype wire
